q_table_update_v3: RTL and testbench
====================================

# q_table_update_v3

Sequential update engine for a node's Q-learning routing table in the clustered WSN routing core. On an `en` pulse it takes the fields of one received packet (`f*`) and searches the external neighbor table, reading entries through the `m*` inputs. It then updates the matching entry in place, or appends a new one. For cluster-head (CH) announcement packets it also appends the announced CH to the known-CH list if absent. The block sits between the packet parser and the neighbor/known-CH memory banks and drives their shared write strobe.

## Interface
- `WORD_WIDTH`, default 16: width of all data, ID, count and index words.
- `MAX_NEIGHBORS`, default 32: neighbor table capacity.
- `MAX_CH`, default 16: known-CH list capacity.
- `PKT_CH_ANNOUNCE`, default 3'b010: packet type that triggers the known-CH update.

Ports:
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous and active-high.
- `en` in 1: start pulse, sampled only in IDLE.
- `fSourceID`, `fSourceHops`, `fClusterID`, `fEnergyLeft`, `fQValue`, `fKnownCH` in 16: packet fields. Energy and Q are unsigned Q2.14, e.g. 0x3000 = 0.75.
- `fPacketType` in 3: packet type, e.g. 3'b101 = data.
- `mSourceID`, `mSourceHops`, `mClusterID`, `mEnergyLeft`, `mQValue` in 16: neighbor entry at address `neighborCount`, combinational read.
- `mNeighborCount` in 16: current number of stored neighbors.
- `mKnownCH` in 16: CH entry at address `knownCHCount`, combinational read.
- `mKnownCHCount` in 16: current number of known CHs.
- `nodeID`, `nodeHops`, `nodeClusterID`, `nodeEnergy`, `nodeQValue` out 16: neighbor write data.
- `neighborCount` out 16: neighbor bank address while busy; the updated neighbor count in DONE and IDLE.
- `knownCH` out 16: CH write data.
- `knownCHCount` out 16: CH bank address while busy; the updated CH count in DONE and IDLE.
- `wr_en` out 1: write strobe, shared by both banks.
- `done` out 1: one-cycle completion pulse.

## Operation
- The FSM has the states IDLE, LOAD, SCAN_N, WRITE_N, SCAN_CH, WRITE_CH and DONE.
- **IDLE**
  - If `en` = 1: latch all `f*` inputs, `mNeighborCount` and `mKnownCHCount`, then go to LOAD.
  - `en` is ignored in every other state.
- **LOAD**: `neighborCount` = 0, `knownCHCount` = 0. Go to SCAN_N.
- **SCAN_N**: evaluates one index i = `neighborCount` per cycle.
  - If i == latched count: append. Go to WRITE_N at address i, unless count == `MAX_NEIGHBORS`. When full, skip the write and go to the CH phase.
  - Else if `mSourceID` == `fSourceID`: update. Go to WRITE_N at address i.
  - Else: i + 1.
- **WRITE_N**
  - `wr_en` = 1.
  - `nodeID` = `fSourceID`, `nodeHops` = `fSourceHops`, `nodeClusterID` = `fClusterID`, `nodeEnergy` = `fEnergyLeft`, `nodeQValue` = `fQValue`. Values are copied verbatim; there is no arithmetic.
  - `knownCH` = `mKnownCH` at the current `knownCHCount`, an idempotent rewrite.
  - Neighbor count after completion: +1 if this was an append, unchanged if an update.
- **CH phase** (entered after WRITE_N or a skipped write)
  - If `fPacketType` == `PKT_CH_ANNOUNCE`: go to SCAN_CH. Otherwise go to DONE.
- **SCAN_CH**: same scan over `knownCHCount`, comparing `mKnownCH` with `fKnownCH`.
  - Match: no write; go to DONE.
  - i == count and count < `MAX_CH`: go to WRITE_CH.
  - Full: go to DONE.
- **WRITE_CH**
  - `wr_en` = 1, `knownCH` = `fKnownCH`, at address i.
  - The neighbor outputs hold the entry just written (idempotent).
  - Known-CH count is +1.
- **DONE**
  - `done` = 1.
  - `neighborCount` and `knownCHCount` present the updated counts.
  - Go to IDLE.
- All outputs are registered and hold their values in IDLE.
- In any cycle with `wr_en` = 1, both banks are written, so the bank that is not the target always receives unchanged data.

## Timing
- Reset, asynchronous and active-high, applies any time, including mid-operation:
  - FSM goes to IDLE.
  - All outputs are 0, including `wr_en` and `done`.
  - Any write in progress is abandoned.
- Let T0 be the edge that samples `en`, and k the index at which the neighbor scan terminates (match index or count).
  - LOAD occupies 1 cycle.
  - SCAN_N occupies k+1 cycles.
  - WRITE_N occupies 1 cycle.
  - DONE occupies 1 cycle.
- Empty table, non-CH packet: `wr_en` is high during cycle T2..T3 and `done` during T3..T4.
- `m*` inputs must be valid in the same cycle that the address is driven.
- `wr_en` is never high for more than one consecutive cycle.
- `done` is high for exactly one cycle per accepted `en`.

## Test plan
- **Empty table, append.** Inputs: `mNeighborCount` = 0, `fSourceID` = 1, `fClusterID` = 2, `fEnergyLeft` = 0x8000, `fQValue` = 0x3000, type 3'b101, `en` pulse. Required: one `wr_en` cycle at `neighborCount` = 0 with `nodeID` = 1, `nodeClusterID` = 2, `nodeEnergy` = 0x8000, `nodeQValue` = 0x3000. Then `done` with `neighborCount` = 1.
- **Update existing neighbor.** Table holds ID 1 at index 0, count 1. Inputs: `fClusterID` = 3, `fEnergyLeft` = 0x1800, `fQValue` = 0xB800. Required: write at index 0 with the new values, and `neighborCount` = 1 at `done`.
- **Append after scan.** Table holds IDs {4, 5, 6}, `fSourceID` = 9. Required: 4 SCAN_N cycles, write at index 3, count 4 at `done`.
- **CH announce.** Type 3'b010, `fKnownCH` = 7, known list {2} with count 1. Required: two `wr_en` pulses (neighbor, then CH at index 1) and `knownCHCount` = 2 at `done`. Repeating with 7 already present gives a single `wr_en` and count unchanged.
- **Full table.** `mNeighborCount` = `MAX_NEIGHBORS`, new ID. Required: no `wr_en`, `done` pulses, count unchanged.
- **Reset mid-operation.** Assert `nrst` during SCAN_N. Required: all outputs are 0 immediately, there is no `done`, and a later `en` runs normally.

Source files
------------

// File: rtl/q_table_update_v3.sv
// Q-learning routing table update engine: scans the external neighbor table for the
// packet source, updates or appends it, then appends an announced cluster head if new.
module q_table_update_v3 #(
    parameter int unsigned WORD_WIDTH      = 16,
    parameter int unsigned MAX_NEIGHBORS   = 32,
    parameter int unsigned MAX_CH          = 16,
    parameter logic [2:0]  PKT_CH_ANNOUNCE = 3'b010
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fClusterID,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fKnownCH,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mSourceHops,
    input  logic [WORD_WIDTH-1:0] mClusterID,
    input  logic [WORD_WIDTH-1:0] mEnergyLeft,
    input  logic [WORD_WIDTH-1:0] mQValue,
    input  logic [WORD_WIDTH-1:0] mNeighborCount,
    input  logic [WORD_WIDTH-1:0] mKnownCH,
    input  logic [WORD_WIDTH-1:0] mKnownCHCount,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeClusterID,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [WORD_WIDTH-1:0] neighborCount,
    output logic [WORD_WIDTH-1:0] knownCH,
    output logic [WORD_WIDTH-1:0] knownCHCount,
    output logic                  wr_en,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] MAX_N_W = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] MAX_C_W = WORD_WIDTH'(MAX_CH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN_N, S_WRITE_N, S_SCAN_CH, S_WRITE_CH, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] f_src_q, f_src_d, f_hops_q, f_hops_d, f_cl_q, f_cl_d;
    logic [WORD_WIDTH-1:0] f_energy_q, f_energy_d, f_qv_q, f_qv_d, f_kch_q, f_kch_d;
    logic [2:0]            f_type_q, f_type_d;
    logic [WORD_WIDTH-1:0] n_cnt_q, n_cnt_d, c_cnt_q, c_cnt_d;
    logic                  n_app_q, n_app_d, c_app_q, c_app_d;
    logic [WORD_WIDTH-1:0] node_id_q, node_id_d, node_hops_q, node_hops_d;
    logic [WORD_WIDTH-1:0] node_cl_q, node_cl_d, node_energy_q, node_energy_d;
    logic [WORD_WIDTH-1:0] node_qv_q, node_qv_d, nb_idx_q, nb_idx_d;
    logic [WORD_WIDTH-1:0] kch_q, kch_d, ch_idx_q, ch_idx_d;
    logic                  wr_en_q, wr_en_d, done_q, done_d;
    logic                  to_ch_phase, to_done;

    // Neighbor payload read-back is not needed; only the ID takes part in the search.
    logic unused_m;
    assign unused_m = ^{mSourceHops, mClusterID, mEnergyLeft, mQValue};

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q       <= S_IDLE;
            f_src_q       <= '0;
            f_hops_q      <= '0;
            f_cl_q        <= '0;
            f_energy_q    <= '0;
            f_qv_q        <= '0;
            f_kch_q       <= '0;
            f_type_q      <= '0;
            n_cnt_q       <= '0;
            c_cnt_q       <= '0;
            n_app_q       <= 1'b0;
            c_app_q       <= 1'b0;
            node_id_q     <= '0;
            node_hops_q   <= '0;
            node_cl_q     <= '0;
            node_energy_q <= '0;
            node_qv_q     <= '0;
            nb_idx_q      <= '0;
            kch_q         <= '0;
            ch_idx_q      <= '0;
            wr_en_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_src_q       <= f_src_d;
            f_hops_q      <= f_hops_d;
            f_cl_q        <= f_cl_d;
            f_energy_q    <= f_energy_d;
            f_qv_q        <= f_qv_d;
            f_kch_q       <= f_kch_d;
            f_type_q      <= f_type_d;
            n_cnt_q       <= n_cnt_d;
            c_cnt_q       <= c_cnt_d;
            n_app_q       <= n_app_d;
            c_app_q       <= c_app_d;
            node_id_q     <= node_id_d;
            node_hops_q   <= node_hops_d;
            node_cl_q     <= node_cl_d;
            node_energy_q <= node_energy_d;
            node_qv_q     <= node_qv_d;
            nb_idx_q      <= nb_idx_d;
            kch_q         <= kch_d;
            ch_idx_q      <= ch_idx_d;
            wr_en_q       <= wr_en_d;
            done_q        <= done_d;
        end
    end

    // Outputs are computed for the state being entered, so they are valid in that state.
    always_comb begin
        state_d       = state_q;
        f_src_d       = f_src_q;
        f_hops_d      = f_hops_q;
        f_cl_d        = f_cl_q;
        f_energy_d    = f_energy_q;
        f_qv_d        = f_qv_q;
        f_kch_d       = f_kch_q;
        f_type_d      = f_type_q;
        n_cnt_d       = n_cnt_q;
        c_cnt_d       = c_cnt_q;
        n_app_d       = n_app_q;
        c_app_d       = c_app_q;
        node_id_d     = node_id_q;
        node_hops_d   = node_hops_q;
        node_cl_d     = node_cl_q;
        node_energy_d = node_energy_q;
        node_qv_d     = node_qv_q;
        nb_idx_d      = nb_idx_q;
        kch_d         = kch_q;
        ch_idx_d      = ch_idx_q;
        wr_en_d       = 1'b0;
        done_d        = 1'b0;
        to_ch_phase   = 1'b0;
        to_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    f_src_d    = fSourceID;
                    f_hops_d   = fSourceHops;
                    f_cl_d     = fClusterID;
                    f_energy_d = fEnergyLeft;
                    f_qv_d     = fQValue;
                    f_kch_d    = fKnownCH;
                    f_type_d   = fPacketType;
                    n_cnt_d    = mNeighborCount;
                    c_cnt_d    = mKnownCHCount;
                    n_app_d    = 1'b0;
                    c_app_d    = 1'b0;
                    nb_idx_d   = '0;
                    ch_idx_d   = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: state_d = S_SCAN_N;
            S_SCAN_N: begin
                if (nb_idx_q == n_cnt_q || mSourceID == f_src_q) begin
                    if (nb_idx_q == n_cnt_q && n_cnt_q >= MAX_N_W) begin
                        to_ch_phase = 1'b1;
                    end else begin
                        n_app_d       = (nb_idx_q == n_cnt_q);
                        node_id_d     = f_src_q;
                        node_hops_d   = f_hops_q;
                        node_cl_d     = f_cl_q;
                        node_energy_d = f_energy_q;
                        node_qv_d     = f_qv_q;
                        kch_d         = mKnownCH;
                        wr_en_d       = 1'b1;
                        state_d       = S_WRITE_N;
                    end
                end else begin
                    nb_idx_d = nb_idx_q + WORD_WIDTH'(1);
                end
            end
            S_WRITE_N: to_ch_phase = 1'b1;
            S_SCAN_CH: begin
                if (ch_idx_q == c_cnt_q) begin
                    if (c_cnt_q >= MAX_C_W) begin
                        to_done = 1'b1;
                    end else begin
                        c_app_d = 1'b1;
                        kch_d   = f_kch_q;
                        wr_en_d = 1'b1;
                        state_d = S_WRITE_CH;
                    end
                end else if (mKnownCH == f_kch_q) begin
                    to_done = 1'b1;
                end else begin
                    ch_idx_d = ch_idx_q + WORD_WIDTH'(1);
                end
            end
            S_WRITE_CH: to_done = 1'b1;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (to_ch_phase) begin
            if (f_type_q == PKT_CH_ANNOUNCE) begin
                state_d = S_SCAN_CH;
            end else begin
                to_done = 1'b1;
            end
        end

        // Count outputs switch from bank addresses to the updated counts on entering DONE.
        if (to_done) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            nb_idx_d = n_cnt_q + WORD_WIDTH'(n_app_d);
            ch_idx_d = c_cnt_q + WORD_WIDTH'(c_app_d);
        end
    end

    assign nodeID        = node_id_q;
    assign nodeHops      = node_hops_q;
    assign nodeClusterID = node_cl_q;
    assign nodeEnergy    = node_energy_q;
    assign nodeQValue    = node_qv_q;
    assign neighborCount = nb_idx_q;
    assign knownCH       = kch_q;
    assign knownCHCount  = ch_idx_q;
    assign wr_en         = wr_en_q;
    assign done          = done_q;

endmodule

// File: tb/tb_q_table_update_v3.sv
// Bench for q_table_update_v3: bench-held neighbor/CH banks, queue-based table model.
module tb_q_table_update_v3;

    localparam int MAXN = 32;
    localparam int MAXC = 16;
    localparam logic [2:0] T_CH   = 3'b010;
    localparam logic [2:0] T_DATA = 3'b101;

    logic        clk = 1'b0;
    logic        nrst, en;
    logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
    logic [2:0]  fPacketType;
    logic [15:0] mSourceID, mSourceHops, mClusterID, mEnergyLeft, mQValue;
    logic [15:0] mNeighborCount, mKnownCH, mKnownCHCount;
    logic [15:0] nodeID, nodeHops, nodeClusterID, nodeEnergy, nodeQValue;
    logic [15:0] neighborCount, knownCH, knownCHCount;
    logic        wr_en, done;

    always #5 clk = ~clk;

    q_table_update_v3 dut (
        .clk(clk), .nrst(nrst), .en(en),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fClusterID(fClusterID),
        .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fKnownCH(fKnownCH),
        .fPacketType(fPacketType),
        .mSourceID(mSourceID), .mSourceHops(mSourceHops), .mClusterID(mClusterID),
        .mEnergyLeft(mEnergyLeft), .mQValue(mQValue), .mNeighborCount(mNeighborCount),
        .mKnownCH(mKnownCH), .mKnownCHCount(mKnownCHCount),
        .nodeID(nodeID), .nodeHops(nodeHops), .nodeClusterID(nodeClusterID),
        .nodeEnergy(nodeEnergy), .nodeQValue(nodeQValue), .neighborCount(neighborCount),
        .knownCH(knownCH), .knownCHCount(knownCHCount), .wr_en(wr_en), .done(done)
    );

    // Memory banks as seen by the DUT: combinational read, write on the strobe.
    logic [15:0] mem_id [64] = '{default: 16'h0};
    logic [15:0] mem_hp [64] = '{default: 16'h0};
    logic [15:0] mem_cl [64] = '{default: 16'h0};
    logic [15:0] mem_en [64] = '{default: 16'h0};
    logic [15:0] mem_qv [64] = '{default: 16'h0};
    logic [15:0] mem_ch [32] = '{default: 16'h0};

    assign mSourceID   = mem_id[neighborCount[5:0]];
    assign mSourceHops = mem_hp[neighborCount[5:0]];
    assign mClusterID  = mem_cl[neighborCount[5:0]];
    assign mEnergyLeft = mem_en[neighborCount[5:0]];
    assign mQValue     = mem_qv[neighborCount[5:0]];
    assign mKnownCH    = mem_ch[knownCHCount[4:0]];

    always @(posedge clk) begin
        if (wr_en) begin
            if (neighborCount < 16'(MAXN)) begin
                mem_id[neighborCount[5:0]] <= nodeID;
                mem_hp[neighborCount[5:0]] <= nodeHops;
                mem_cl[neighborCount[5:0]] <= nodeClusterID;
                mem_en[neighborCount[5:0]] <= nodeEnergy;
                mem_qv[neighborCount[5:0]] <= nodeQValue;
            end
            if (knownCHCount < 16'(MAXC)) mem_ch[knownCHCount[4:0]] <= knownCH;
        end
    end

    // Reference table: logical contents only, in insertion order.
    logic [15:0] ref_id[$], ref_hp[$], ref_cl[$], ref_en[$], ref_qv[$], ref_ch[$];

    int total = 0;
    int bad   = 0;

    // Write beats recorded during the last operation.
    logic [15:0] bt_nc[2], bt_id[2], bt_hp[2], bt_cl[2], bt_en[2], bt_qv[2], bt_kc[2], bt_kch[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tables();
        ref_id.delete(); ref_hp.delete(); ref_cl.delete();
        ref_en.delete(); ref_qv.delete(); ref_ch.delete();
    endtask

    task automatic do_op(input logic [15:0] src, hops, cl, enr, qv, input logic [2:0] typ,
                         input logic [15:0] kch);
        int k, c, nsz, csz, exp_lat, exp_wr, cyc, wr, lat, consec, terr;
        bit n_full, ch_wr, prev_wr, seen;
        logic [15:0] done_nc, done_kc;
        nsz = ref_id.size();
        csz = ref_ch.size();
        k = nsz;
        for (int i = 0; i < nsz; i++) if (ref_id[i] == src) begin k = i; break; end
        n_full  = (k == nsz) && (nsz >= MAXN);
        exp_wr  = n_full ? 0 : 1;
        exp_lat = 1 + (k + 1) + exp_wr + 1;
        if (!n_full) begin
            if (k == nsz) begin
                ref_id.push_back(src); ref_hp.push_back(hops); ref_cl.push_back(cl);
                ref_en.push_back(enr); ref_qv.push_back(qv);
            end else begin
                ref_hp[k] = hops; ref_cl[k] = cl; ref_en[k] = enr; ref_qv[k] = qv;
            end
        end
        ch_wr = 1'b0;
        c = csz;
        if (typ == T_CH) begin
            for (int i = 0; i < csz; i++) if (ref_ch[i] == kch) begin c = i; break; end
            exp_lat += c + 1;
            if (c == csz && csz < MAXC) begin
                ch_wr = 1'b1;
                ref_ch.push_back(kch);
                exp_lat += 1;
                exp_wr += 1;
            end
        end

        @(negedge clk);
        fSourceID = src; fSourceHops = hops; fClusterID = cl; fEnergyLeft = enr;
        fQValue = qv; fPacketType = typ; fKnownCH = kch;
        mNeighborCount = 16'(nsz); mKnownCHCount = 16'(csz);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        fSourceID = 16'($urandom); fClusterID = 16'($urandom); fQValue = 16'($urandom);
        fKnownCH = 16'($urandom); fPacketType = 3'($urandom);
        mNeighborCount = 16'($urandom); mKnownCHCount = 16'($urandom);

        cyc = 0; wr = 0; lat = 0; consec = 0; prev_wr = 1'b0; seen = 1'b0;
        done_nc = '0; done_kc = '0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wr_en) begin
                if (prev_wr) consec++;
                if (wr < 2) begin
                    bt_nc[wr] = neighborCount; bt_id[wr] = nodeID; bt_hp[wr] = nodeHops;
                    bt_cl[wr] = nodeClusterID; bt_en[wr] = nodeEnergy; bt_qv[wr] = nodeQValue;
                    bt_kc[wr] = knownCHCount;  bt_kch[wr] = knownCH;
                end
                wr++;
            end
            prev_wr = wr_en;
            if (done) begin
                seen = 1'b1; lat = cyc; done_nc = neighborCount; done_kc = knownCHCount;
            end
        end
        chk("done_latency", lat, exp_lat);
        chk("wr_pulses", wr, exp_wr);
        chk("wr_back_to_back", consec, 0);
        chk("done_nb_count", done_nc, 32'(ref_id.size()));
        chk("done_ch_count", done_kc, 32'(ref_ch.size()));
        if (!n_full && wr >= 1) begin
            chk("nb_wr_addr", bt_nc[0], 32'(k));
            chk("nb_wr_data", {bt_id[0], bt_cl[0]}, {src, cl});
            chk("nb_wr_data2", {bt_en[0], bt_qv[0]}, {enr, qv});
            chk("nb_wr_hops", bt_hp[0], hops);
        end
        if (ch_wr && wr == exp_wr) begin
            chk("ch_wr_addr", bt_kc[exp_wr - 1], 32'(c));
            chk("ch_wr_data", bt_kch[exp_wr - 1], kch);
        end
        @(negedge clk);
        chk("done_width", done, 0);
        chk("idle_hold_counts", {neighborCount, knownCHCount},
            {16'(ref_id.size()), 16'(ref_ch.size())});
        terr = 0;
        for (int i = 0; i < ref_id.size(); i++)
            if (mem_id[6'(i)] !== ref_id[i] || mem_hp[6'(i)] !== ref_hp[i] ||
                mem_cl[6'(i)] !== ref_cl[i] || mem_en[6'(i)] !== ref_en[i] ||
                mem_qv[6'(i)] !== ref_qv[i]) terr++;
        for (int i = 0; i < ref_ch.size(); i++)
            if (mem_ch[5'(i)] !== ref_ch[i]) terr++;
        chk("table_contents", terr, 0);
    endtask

    initial begin
        nrst = 1'b1; en = 1'b0;
        fSourceID = '0; fSourceHops = '0; fClusterID = '0; fEnergyLeft = '0;
        fQValue = '0; fKnownCH = '0; fPacketType = '0;
        mNeighborCount = '0; mKnownCHCount = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {wr_en, done}, 0);
        chk("rst_counts", {neighborCount, knownCHCount}, 0);
        chk("rst_node", {nodeID, nodeClusterID}, 0);
        chk("rst_knownch", knownCH, 0);
        nrst = 1'b0;

        // Empty table append, then update of the same neighbor.
        clear_tables();
        do_op(16'd1, 16'd1, 16'd2, 16'h8000, 16'h3000, T_DATA, 16'd0);
        do_op(16'd1, 16'd2, 16'd3, 16'h1800, 16'hB800, T_DATA, 16'd0);

        // Append after scanning {4,5,6}.
        clear_tables();
        do_op(16'd4, 16'd1, 16'd1, 16'h1000, 16'h0100, T_DATA, 16'd0);
        do_op(16'd5, 16'd1, 16'd1, 16'h2000, 16'h0200, T_DATA, 16'd0);
        do_op(16'd6, 16'd1, 16'd1, 16'h3000, 16'h0300, T_DATA, 16'd0);
        do_op(16'd9, 16'd3, 16'd4, 16'h4000, 16'h0400, T_DATA, 16'd0);

        // CH announce: list {2}, add 7, then 7 again.
        clear_tables();
        do_op(16'd50, 16'd1, 16'd2, 16'h4000, 16'h1000, T_CH, 16'd2);
        do_op(16'd51, 16'd1, 16'd7, 16'h4000, 16'h1000, T_CH, 16'd7);
        do_op(16'd51, 16'd2, 16'd7, 16'h3000, 16'h2000, T_CH, 16'd7);

        // Randomized traffic over a small ID space so updates and matches occur.
        for (int n = 0; n < 40; n++)
            do_op(16'($urandom_range(1, 12)), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom),
                  ($urandom_range(0, 1) != 0) ? T_CH : T_DATA,
                  16'($urandom_range(1, 20)));

        // Fill the neighbor table, then hit it with new sources.
        while (ref_id.size() < MAXN)
            do_op(16'(300 + ref_id.size()), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), T_DATA, 16'd0);
        do_op(16'd999, 16'd1, 16'd1, 16'h1111, 16'h2222, T_DATA, 16'd0);
        do_op(16'd998, 16'd1, 16'd1, 16'h1111, 16'h2222, T_CH, 16'd33);
        do_op(16'd305, 16'd9, 16'd9, 16'h5555, 16'h6666, T_DATA, 16'd0);

        // Reset during the neighbor scan.
        clear_tables();
        for (int n = 0; n < 6; n++)
            do_op(16'(20 + n), 16'd1, 16'd1, 16'h0800, 16'h0400, T_DATA, 16'd0);
        @(negedge clk);
        fSourceID = 16'd99; fPacketType = T_DATA;
        mNeighborCount = 16'd6; mKnownCHCount = 16'd0;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("midrst_ctrl", {wr_en, done}, 0);
        chk("midrst_counts", {neighborCount, knownCHCount}, 0);
        chk("midrst_node", {nodeID, knownCH}, 0);
        @(negedge clk);
        nrst = 1'b0;
        begin
            int stray;
            stray = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || wr_en) stray++;
            end
            chk("midrst_no_activity", stray, 0);
        end
        do_op(16'd99, 16'd2, 16'd5, 16'h0C00, 16'h0A00, T_DATA, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
